// File: rtl/tinychip_pkg.sv
// Shared widths, types and requester indices for the register file slice.
package tinychip_pkg;

    localparam int RF_AW      = 3;
    localparam int RF_DW      = 8;
    localparam int RF_NUM_REQ = 3;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    // Writeback requester slots, lowest index first in the request vectors
    localparam int REQ_ALU   = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_DEBUG = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer and wraps.
// The pointer moves past the winner only when the caller says the grant is taken.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   idx;
    logic          found;

    // Scan N slots starting at the pointer; first requester found wins
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
            if (!found && req[idx[PW-1:0]]) begin
                found                = 1'b1;
                gnt[idx[PW-1:0]]     = 1'b1;
                ptr_d = (idx == (PW+1)'(N-1)) ? '0 : idx[PW-1:0] + PW'(1);
            end
        end
        if (!advance) ptr_d = ptr_q;
    end

    // Pointer register; holds when nothing is granted
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among writeback requesters and keeps a
// per-register busy scoreboard for the issue stage. Register 0 is hardwired.
module regfile_write_arbiter
    import tinychip_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int AW      = RF_AW,
    parameter int DW      = RF_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic                  reserve_valid,
    input  logic [AW-1:0]         reserve_addr,
    output logic                  reserve_ready,
    output logic [2**AW-1:0]      busy,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata
);

    localparam int NUM_REGS = 2**AW;

    logic                blocked;
    logic [NUM_REQ-1:0]  arb_req, gnt;
    logic                g_any;
    logic [AW-1:0]       g_addr;
    logic [DW-1:0]       g_data;

    logic                rf_we_q, rf_we_d;
    logic [AW-1:0]       rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]       rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // No grants (and no pointer movement) while in reset or flushing
    assign blocked = reset | flush;
    assign arb_req = blocked ? '0 : req_valid;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (!blocked),
        .gnt     (gnt)
    );

    assign req_ready     = gnt;
    assign reserve_ready = !busy_q[reserve_addr] && !flush;
    assign busy          = busy_q;
    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;

    // Select the granted requester's address and data
    always_comb begin
        g_any  = 1'b0;
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                g_any  = 1'b1;
                g_addr = req_addr[i*AW +: AW];
                g_data = req_data[i*DW +: DW];
            end
        end
    end

    // Next write-port values; writes to register 0 are accepted but dropped
    always_comb begin
        rf_we_d    = g_any && (g_addr != '0);
        rf_waddr_d = rf_we_d ? g_addr : rf_waddr_q;
        rf_wdata_d = rf_we_d ? g_data : rf_wdata_q;
    end

    // Scoreboard: completed write clears, reservation sets (set wins), flush wipes
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
        if (reserve_valid && reserve_ready && (reserve_addr != '0))
            busy_d[reserve_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    // Output register and scoreboard state
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: driver predicts grants/scoreboard from a behavioural model
// and queues expected writes; a monitor pops them whenever rf_we is seen.
module tb_regfile_write_arbiter;
    import tinychip_pkg::*;

    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NR = 8;

    logic            clk = 1'b0;
    logic            reset, flush;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            reserve_valid, reserve_ready;
    logic [AW-1:0]   reserve_addr;
    logic [NR-1:0]   busy;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .reserve_ready (reserve_ready),
        .busy          (busy),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    // requester side
    bit pend[N];
    int paddr[N];
    int pdata[N];

    // reference model
    int ptr;
    bit mbusy[NR];
    bit mwe;
    int maddr;
    int hold_addr, hold_data;

    typedef struct { int addr; int data; } wr_t;
    wr_t q[$];

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int busy_vec();
        int v = 0;
        for (int r = 0; r < NR; r++) if (mbusy[r]) v |= (1 << r);
        return v;
    endfunction

    task automatic clear_model_busy();
        for (int r = 0; r < NR; r++) mbusy[r] = 1'b0;
    endtask

    task automatic refill(input int i, input int a, input int d);
        pend[i]  = 1'b1;
        paddr[i] = a;
        pdata[i] = d;
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model at posedge
    task automatic step(input bit rst, input bit fl, input bit rv, input int ra);
        int win;
        int exp_rdy;
        bit exp_rr;
        reset         = rst;
        flush         = fl;
        reserve_valid = rv;
        reserve_addr  = AW'(ra);
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_addr[i*AW +: AW]   = AW'(paddr[i]);
            req_data[i*DW +: DW]   = DW'(pdata[i]);
        end
        #1;
        win = -1;
        if (!rst && !fl)
            for (int k = 0; k < N; k++)
                if (win < 0 && pend[(ptr + k) % N]) win = (ptr + k) % N;
        exp_rdy = (win < 0) ? 0 : (1 << win);
        exp_rr  = !mbusy[ra] && !fl;
        check("req_ready", 32'(req_ready), exp_rdy);
        check("reserve_ready", 32'(reserve_ready), 32'(exp_rr));
        check("busy", 32'(busy), busy_vec());
        @(posedge clk);
        if (rst) begin
            ptr = 0;
            clear_model_busy();
            mwe = 1'b0;
            hold_addr = 0;
            hold_data = 0;
        end else begin
            if (mwe) mbusy[maddr] = 1'b0;
            if (rv && exp_rr && ra != 0) mbusy[ra] = 1'b1;
            if (fl) clear_model_busy();
            mwe = 1'b0;
            if (win >= 0) begin
                ptr = (win + 1) % N;
                pend[win] = 1'b0;
                if (paddr[win] != 0) begin
                    mwe       = 1'b1;
                    maddr     = paddr[win];
                    hold_addr = paddr[win];
                    hold_data = pdata[win];
                    q.push_back('{paddr[win], pdata[win]});
                end
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every rf_we pulse must match the oldest expected write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rf_we === 1'b1) begin
                    if (q.size() == 0) begin
                        check("rf_we_unexpected", 32'(rf_we), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("rf_waddr", 32'(rf_waddr), e.addr);
                        check("rf_wdata", 32'(rf_wdata), e.data);
                    end
                end else begin
                    check("rf_we", 32'(rf_we), 32'd0);
                    check("rf_waddr_hold", 32'(rf_waddr), hold_addr);
                    check("rf_wdata_hold", 32'(rf_wdata), hold_data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        reserve_valid = 1'b0; reserve_addr = '0;
        ptr = 0; mwe = 1'b0; maddr = 0; hold_addr = 0; hold_data = 0;
        clear_model_busy();
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; paddr[i] = 0; pdata[i] = 0; end
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;

        // reset held with every requester valid: nothing granted, nothing written
        for (int i = 0; i < N; i++) refill(i, i + 1, 16 * i + 7);
        step(1, 0, 0, 0);
        step(1, 0, 1, 4);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        step(1, 0, 0, 0);

        // single ALU write
        refill(REQ_ALU, 3, 8'hA5);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // round-robin from pointer 0 with all requesters kept busy
        step(1, 0, 0, 0);
        repeat (6) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) refill(i, $urandom_range(1, NR - 1), $urandom_range(0, 255));
            step(0, 0, 0, 0);
        end
        repeat (4) step(0, 0, 0, 0);

        // scoreboard reserve / re-reserve / clear by load write
        step(0, 0, 1, 5);
        step(0, 0, 1, 5);
        refill(REQ_LOAD, 5, 8'h3C);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // reserve 5 in the same cycle its write lands: set wins
        refill(REQ_LOAD, 5, 8'h5A);
        step(0, 0, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 0, 0);

        // build busy=FE, then flush with everyone requesting
        for (int r = 1; r < NR; r++) step(0, 0, 1, r);
        for (int i = 0; i < N; i++) refill(i, i + 2, 8'h40 + i);
        step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // write to hardwired register 0
        refill(REQ_DEBUG, 0, 8'hFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // randomized traffic
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && ($urandom_range(0, 1) == 1))
                    refill(i, $urandom_range(0, NR - 1), $urandom_range(0, 255));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1), $urandom_range(0, NR - 1));
        end

        // drain
        repeat (6) step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("pending_writes", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
